// File: rtl/send_sched_pkg.sv
// Shared types and widths for the packet-send scheduler.
//   sched_state_t : scheduler FSM states
//   ADDR_W        : width of the packet start RAM address
//   CNT_W         : width of the issued/skipped statistics counters
package send_sched_pkg;

  localparam int ADDR_W = 25;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT1 = 3'd1,
    HOLD1 = 3'd2,
    WAIT2 = 3'd3,
    HOLD2 = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sched_sat_cnt.sv
// Saturating statistics counter: counts inc pulses and sticks at all-ones.
//   clk   : clock
//   rst   : asynchronous, active-high clear
//   inc   : count enable for one cycle
//   count : current value, registered
module sched_sat_cnt
  import send_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pkt_send_scheduler.sv
// Periodic transmit scheduler for the two packet-sender channels.
// Alternates send commands between channel 1 and channel 2, each held high
// for CMD_HOLD cycles and accompanied by its RAM start address. Commands are
// only issued while go = mac_inited & rx_ready; a slot whose channel reports
// busy on its timeout cycle is skipped and the other channel's wait begins.
//
// Optional feature macro: SEND_SCHED_STATS_EN enables the issued/skipped
// counters; without it those outputs read 0 and no counter logic exists.
//
// Ports:
//   clk_50_pll, main_reset (async, active-high)
//   mac_inited, rx_ready     : scheduling enable inputs
//   busy_1, busy_2           : channel busy, sampled on the timeout cycle
//   cmd_send_1/2             : registered send commands
//   start_ram_addr_1/2       : registered packet start addresses
//   issued_1/2, skipped_1/2  : registered saturating statistics
module pkt_send_scheduler
  import send_sched_pkg::*;
#(
  parameter int unsigned       PERIOD   = 100_000_000,
  parameter int unsigned       GAP      = 16_777_216,
  parameter int unsigned       CMD_HOLD = 3,
  parameter logic [ADDR_W-1:0] ADDR_1   = 25'd1,
  parameter logic [ADDR_W-1:0] ADDR_2   = 25'd1
) (
  input  logic              clk_50_pll,
  input  logic              main_reset,
  input  logic              mac_inited,
  input  logic              rx_ready,
  input  logic              busy_1,
  input  logic              busy_2,
  output logic              cmd_send_1,
  output logic              cmd_send_2,
  output logic [ADDR_W-1:0] start_ram_addr_1,
  output logic [ADDR_W-1:0] start_ram_addr_2,
  output logic [CNT_W-1:0]  issued_1,
  output logic [CNT_W-1:0]  issued_2,
  output logic [CNT_W-1:0]  skipped_1,
  output logic [CNT_W-1:0]  skipped_2
);

  if (PERIOD < 2) begin : g_bad_period
    $error("pkt_send_scheduler: PERIOD must be at least 2");
  end
  if (GAP < 2) begin : g_bad_gap
    $error("pkt_send_scheduler: GAP must be at least 2");
  end
  if (CMD_HOLD < 1) begin : g_bad_hold
    $error("pkt_send_scheduler: CMD_HOLD must be at least 1");
  end

  // Terminal timer values: a state of length L leaves when timer == L-1.
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD - 1);
  localparam logic [31:0] GAP_LAST    = 32'(GAP - 1);
  localparam logic [31:0] HOLD_LAST   = 32'(CMD_HOLD - 1);

  sched_state_t state, state_nxt;
  logic [31:0]  timer;
  logic         go;
  logic         timeout_1, timeout_2;
  logic         issue_1, issue_2;

  assign go        = mac_inited & rx_ready;
  assign timeout_1 = go && (state == WAIT1) && (timer == PERIOD_LAST);
  assign timeout_2 = go && (state == WAIT2) && (timer == GAP_LAST);
  assign issue_1   = timeout_1 & ~busy_1;
  assign issue_2   = timeout_2 & ~busy_2;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = WAIT1;
      WAIT1:   if (timer == PERIOD_LAST) state_nxt = busy_1 ? WAIT2 : HOLD1;
      HOLD1:   if (timer == HOLD_LAST)   state_nxt = WAIT2;
      WAIT2:   if (timer == GAP_LAST)    state_nxt = busy_2 ? WAIT1 : HOLD2;
      HOLD2:   if (timer == HOLD_LAST)   state_nxt = WAIT1;
      default: state_nxt = IDLE;
    endcase
    // Losing go overrides everything, including the IDLE exit.
    if (!go) state_nxt = IDLE;
  end

  always_ff @(posedge clk_50_pll or posedge main_reset) begin
    if (main_reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      // Timer restarts on every state change and rests at 0 in IDLE.
      if ((state_nxt != state) || (state_nxt == IDLE)) timer <= '0;
      else                                             timer <= timer + 32'd1;
    end
  end

  // Commands are registered copies of the next state, so they rise and fall
  // on the very edge the FSM enters or leaves a HOLD state.
  always_ff @(posedge clk_50_pll or posedge main_reset) begin
    if (main_reset) begin
      cmd_send_1       <= 1'b0;
      cmd_send_2       <= 1'b0;
      start_ram_addr_1 <= '0;
      start_ram_addr_2 <= '0;
    end else begin
      cmd_send_1 <= (state_nxt == HOLD1);
      cmd_send_2 <= (state_nxt == HOLD2);
      if (issue_1) start_ram_addr_1 <= ADDR_1;
      if (issue_2) start_ram_addr_2 <= ADDR_2;
    end
  end

`ifdef SEND_SCHED_STATS_EN
  logic skip_1, skip_2;
  assign skip_1 = timeout_1 & busy_1;
  assign skip_2 = timeout_2 & busy_2;

  sched_sat_cnt u_issued_1  (.clk(clk_50_pll), .rst(main_reset), .inc(issue_1), .count(issued_1));
  sched_sat_cnt u_issued_2  (.clk(clk_50_pll), .rst(main_reset), .inc(issue_2), .count(issued_2));
  sched_sat_cnt u_skipped_1 (.clk(clk_50_pll), .rst(main_reset), .inc(skip_1),  .count(skipped_1));
  sched_sat_cnt u_skipped_2 (.clk(clk_50_pll), .rst(main_reset), .inc(skip_2),  .count(skipped_2));
`else
  assign issued_1  = '0;
  assign issued_2  = '0;
  assign skipped_1 = '0;
  assign skipped_2 = '0;
`endif

endmodule

// File: tb/tb_pkt_send_scheduler.sv
// Bench for pkt_send_scheduler (PERIOD=16, GAP=8, CMD_HOLD=3, ADDR_1=5,
// ADDR_2=9) plus a standalone sched_sat_cnt for the saturation boundary.
// A deadline-based model predicts every output each cycle; directed
// literal checks pin the model to hand-computed timing.
module tb_pkt_send_scheduler;
  import send_sched_pkg::*;

  localparam int P  = 16;
  localparam int G  = 8;
  localparam int H  = 3;
  localparam int A1 = 5;
  localparam int A2 = 9;
`ifdef SEND_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk_50_pll = 1'b0;
  logic              main_reset, mac_inited, rx_ready, busy_1, busy_2;
  logic              cmd_send_1, cmd_send_2;
  logic [ADDR_W-1:0] start_ram_addr_1, start_ram_addr_2;
  logic [CNT_W-1:0]  issued_1, issued_2, skipped_1, skipped_2;
  logic              sat_rst, sat_inc;
  logic [CNT_W-1:0]  sat_cnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk_50_pll = ~clk_50_pll;

  pkt_send_scheduler #(
    .PERIOD(P), .GAP(G), .CMD_HOLD(H), .ADDR_1(25'd5), .ADDR_2(25'd9)
  ) dut (
    .clk_50_pll(clk_50_pll), .main_reset(main_reset),
    .mac_inited(mac_inited), .rx_ready(rx_ready),
    .busy_1(busy_1), .busy_2(busy_2),
    .cmd_send_1(cmd_send_1), .cmd_send_2(cmd_send_2),
    .start_ram_addr_1(start_ram_addr_1), .start_ram_addr_2(start_ram_addr_2),
    .issued_1(issued_1), .issued_2(issued_2),
    .skipped_1(skipped_1), .skipped_2(skipped_2)
  );

  sched_sat_cnt u_sat (.clk(clk_50_pll), .rst(sat_rst), .inc(sat_inc), .count(sat_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 wait ch1, 2 send ch1, 3 wait ch2, 4 send ch2;
  // 'due' is the absolute edge number at which the current phase ends.
  int cyc = 0;
  int ph  = 0;
  int due = 0;
  int m_a1 = 0, m_a2 = 0;
  int m_is1 = 0, m_is2 = 0, m_sk1 = 0, m_sk2 = 0;

  function automatic int bump(input int v);
    return (STATS && v < 16'hFFFF) ? v + 1 : v;
  endfunction

  always @(posedge clk_50_pll) begin
    cyc++;
    if (main_reset) begin
      ph = 0; m_a1 = 0; m_a2 = 0;
      m_is1 = 0; m_is2 = 0; m_sk1 = 0; m_sk2 = 0;
    end else if (!(mac_inited && rx_ready)) begin
      ph = 0;
    end else begin
      case (ph)
        0: begin ph = 1; due = cyc + P; end
        1: if (cyc == due) begin
             if (busy_1) begin ph = 3; due = cyc + G; m_sk1 = bump(m_sk1); end
             else begin ph = 2; due = cyc + H; m_a1 = A1; m_is1 = bump(m_is1); end
           end
        2: if (cyc == due) begin ph = 3; due = cyc + G; end
        3: if (cyc == due) begin
             if (busy_2) begin ph = 1; due = cyc + P; m_sk2 = bump(m_sk2); end
             else begin ph = 4; due = cyc + H; m_a2 = A2; m_is2 = bump(m_is2); end
           end
        default: if (cyc == due) begin ph = 1; due = cyc + P; end
      endcase
    end
    #1;
    chk("model_cmd1",  32'(cmd_send_1), 32'(ph == 2));
    chk("model_cmd2",  32'(cmd_send_2), 32'(ph == 4));
    chk("model_addr1", 32'(start_ram_addr_1), m_a1);
    chk("model_addr2", 32'(start_ram_addr_2), m_a2);
    chk("model_iss1",  32'(issued_1),  m_is1);
    chk("model_iss2",  32'(issued_2),  m_is2);
    chk("model_skp1",  32'(skipped_1), m_sk1);
    chk("model_skp2",  32'(skipped_2), m_sk2);
    chk("exclusive",   32'(cmd_send_1 & cmd_send_2), 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50_pll);
    #2;
  endtask

  task automatic do_reset();
    main_reset = 1'b1; mac_inited = 1'b0; rx_ready = 1'b0;
    busy_1 = 1'b0; busy_2 = 1'b0;
    tick(2);
    main_reset = 1'b0;
    tick(1);
  endtask

  initial begin
    main_reset = 1'b1; mac_inited = 1'b0; rx_ready = 1'b0;
    busy_1 = 1'b0; busy_2 = 1'b0; sat_rst = 1'b1; sat_inc = 1'b0;
    #1;
    chk("rst_cmd1",  32'(cmd_send_1), 0);
    chk("rst_addr1", 32'(start_ram_addr_1), 0);
    chk("rst_iss1",  32'(issued_1), 0);
    tick(3);
    main_reset = 1'b0; sat_rst = 1'b0;

    // Scenario 1: nominal alternation
    tick(9);
    mac_inited = 1'b1; rx_ready = 1'b1;
    tick(16); chk("s1_cmd1_before", 32'(cmd_send_1), 0);
    tick(1);  chk("s1_cmd1_rise", 32'(cmd_send_1), 1);
              chk("s1_addr1", 32'(start_ram_addr_1), A1);
    tick(2);  chk("s1_cmd1_last", 32'(cmd_send_1), 1);
    tick(1);  chk("s1_cmd1_fall", 32'(cmd_send_1), 0);
    tick(7);  chk("s1_cmd2_before", 32'(cmd_send_2), 0);
    tick(1);  chk("s1_cmd2_rise", 32'(cmd_send_2), 1);
              chk("s1_addr2", 32'(start_ram_addr_2), A2);
    tick(3);  chk("s1_cmd2_fall", 32'(cmd_send_2), 0);
    tick(15); chk("s1_cmd1_again_before", 32'(cmd_send_1), 0);
    tick(1);  chk("s1_cmd1_again", 32'(cmd_send_1), 1);
              chk("s1_issued1", 32'(issued_1), STATS ? 2 : 0);

    // Scenario 2: channel 1 busy at its timeout
    do_reset();
    busy_1 = 1'b1; mac_inited = 1'b1; rx_ready = 1'b1;
    tick(17); chk("s2_no_cmd1", 32'(cmd_send_1), 0);
              chk("s2_addr1", 32'(start_ram_addr_1), 0);
              chk("s2_skipped1", 32'(skipped_1), STATS ? 1 : 0);
    busy_1 = 1'b0;
    tick(7);  chk("s2_cmd2_before", 32'(cmd_send_2), 0);
    tick(1);  chk("s2_cmd2_rise", 32'(cmd_send_2), 1);

    // Scenario 3: rx_ready drops mid-send
    do_reset();
    mac_inited = 1'b1; rx_ready = 1'b1;
    tick(18); chk("s3_in_hold", 32'(cmd_send_1), 1);
    rx_ready = 1'b0;
    tick(1);  chk("s3_cmd1_drop", 32'(cmd_send_1), 0);
              chk("s3_addr_kept", 32'(start_ram_addr_1), A1);
    tick(3);
    rx_ready = 1'b1;
    tick(16); chk("s3_restart_before", 32'(cmd_send_1), 0);
    tick(1);  chk("s3_restart_cmd1", 32'(cmd_send_1), 1);

    // Scenario 4: reset during channel 2 wait
    do_reset();
    mac_inited = 1'b1; rx_ready = 1'b1;
    tick(25); chk("s4_wait2_cmd2", 32'(cmd_send_2), 0);
              chk("s4_pre_addr1", 32'(start_ram_addr_1), A1);
    main_reset = 1'b1;
    #1;
    chk("s4_async_addr1", 32'(start_ram_addr_1), 0);
    chk("s4_async_cmd1",  32'(cmd_send_1), 0);
    chk("s4_async_iss1",  32'(issued_1), 0);
    tick(2);
    main_reset = 1'b0;
    tick(16); chk("s4_first_cmd2", 32'(cmd_send_2), 0);
              chk("s4_first_before", 32'(cmd_send_1), 0);
    tick(1);  chk("s4_first_cmd1", 32'(cmd_send_1), 1);

    // Scenario 6: random busy and go activity
    for (int i = 0; i < 1000; i++) begin
      busy_1     = ($urandom_range(0, 3) == 0);
      busy_2     = ($urandom_range(0, 3) == 0);
      mac_inited = ($urandom_range(0, 39) != 0);
      rx_ready   = ($urandom_range(0, 39) != 0);
      tick(1);
    end
    mac_inited = 1'b0; rx_ready = 1'b0; busy_1 = 1'b0; busy_2 = 1'b0;
    tick(2);

    // Saturation boundary on the counter sub-module
    sat_inc = 1'b1;
    tick(65534); chk("sat_fffe", 32'(sat_cnt), 32'hFFFE);
    tick(1);     chk("sat_ffff", 32'(sat_cnt), 32'hFFFF);
    tick(3);     chk("sat_stick", 32'(sat_cnt), 32'hFFFF);
    sat_inc = 1'b0;
    tick(1);     chk("sat_hold", 32'(sat_cnt), 32'hFFFF);
    sat_rst = 1'b1;
    #1;          chk("sat_clear", 32'(sat_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pkt_send_scheduler.md
# pkt_send_scheduler

Periodic transmit scheduler for the two packet-sender channels feeding the TSE MACs. Raises `cmd_send_1` and `cmd_send_2` in strict alternation, each with its own RAM start address, and holds each pulse for a fixed number of cycles. Issues commands only while the MAC is initialised and the PHY receive path is ready, and skips a slot whose channel reports busy. Sits in the top level between the platform system's init/reset status and its `send_packet_*_control` conduits.

## Interface
- `PERIOD`, 100_000_000: cycles from entering the WAIT1 state to the channel-1 command.
- `GAP`, 16_777_216: cycles from entering the WAIT2 state to the channel-2 command.
- `CMD_HOLD`, 3: cycles each `cmd_send_x` stays high; must be ≥1.
- `ADDR_1`, 25'd1: start RAM address for channel 1.
- `ADDR_2`, 25'd1: start RAM address for channel 2.
- `clk_50_pll`  in  1  system clock.
- `main_reset`  in  1  asynchronous, active-high reset.
- `mac_inited`  in  1  MAC configuration complete.
- `rx_ready`  in  1  PHY reset controller RX ready.
- `busy_1`, `busy_2`  in  1  channel transmitter busy.
- `cmd_send_1`, `cmd_send_2`  out  1  send command to the channel.
- `start_ram_addr_1`, `start_ram_addr_2`  out  25  packet start address.
- `issued_1`, `issued_2`  out  16  commands issued per channel.
- `skipped_1`, `skipped_2`  out  16  slots skipped because the channel was busy.

## Operation
- FSM states:
  - IDLE → WAIT1 when `go` = `mac_inited & rx_ready`.
  - WAIT1: timer counts up. At timer == PERIOD-1:
    - `busy_1` = 0 → HOLD1.
    - `busy_1` = 1 → WAIT2, and `skipped_1` increments.
  - HOLD1: `cmd_send_1` = 1 for CMD_HOLD cycles, then → WAIT2.
  - WAIT2 and HOLD2 behave the same way for channel 2. HOLD2 (or a skip in WAIT2) → WAIT1.
- On every state change the timer clears to 0. Timer is 32 bits.
- `busy_x` is sampled only on the timeout cycle.
- Entering HOLDx:
  - `start_ram_addr_x` loads ADDR_x on the same edge that `cmd_send_x` rises.
  - `issued_x` increments.
  - The address holds its value until the next load.
- `go` falling in any state → IDLE on the next edge. `cmd_send_*` drop at that edge; addresses keep their values.
- `cmd_send_1` and `cmd_send_2` are never high in the same cycle.
- Counters saturate at 16'hFFFF.
- Parameter checks at elaboration: PERIOD ≥ 2, GAP ≥ 2, CMD_HOLD ≥ 1.

## Timing
- Reset values: state IDLE, timer 0, all `cmd_send_*` 0, addresses 0, all counters 0.
- All outputs are registered. Nothing is combinational from inputs to outputs.
- `go` rising at edge N: state is WAIT1 after edge N+1. `cmd_send_1` is high after edge N+1+PERIOD.
- After `cmd_send_1` falls, `cmd_send_2` rises GAP cycles later.
- After `cmd_send_2` falls, `cmd_send_1` rises PERIOD cycles later.
- A skipped slot still uses its full wait. The next channel's wait starts on the skip edge.
- Reset asserted mid-HOLD clears all outputs immediately (asynchronously).

## Configuration
- `SEND_SCHED_STATS_EN` defined: the four counters are implemented as described.
- `SEND_SCHED_STATS_EN` undefined:
  - `issued_*` and `skipped_*` are tied to 0 and no counter logic is generated.
  - Scheduling and skip behaviour are unchanged.

## Structure
- Package `send_sched_pkg` holds:
  - state enum `sched_state_t` (IDLE, WAIT1, HOLD1, WAIT2, HOLD2);
  - `ADDR_W` = 25;
  - `CNT_W` = 16.
- One sub-module, `sched_sat_cnt`: a saturating CNT_W-bit counter with `clk`, `rst`, and `inc` inputs. It is instantiated four times inside the `SEND_SCHED_STATS_EN` guard.

## Test plan
All scenarios use PERIOD=16, GAP=8, CMD_HOLD=3, ADDR_1=5, ADDR_2=9.

1. Raise `go` at cycle 10.
   - `cmd_send_1` is high for cycles 27–29 with `start_ram_addr_1` = 5.
   - `cmd_send_2` is high for cycles 38–40 with `start_ram_addr_2` = 9.
   - `cmd_send_1` is high again at cycle 57.
   - `issued_1` = 2.
2. Hold `busy_1` = 1 over the channel-1 timeout.
   - No `cmd_send_1` is issued; `skipped_1` = 1.
   - `cmd_send_2` rises 8 cycles after the skip edge.
3. Drop `rx_ready` during HOLD1.
   - `cmd_send_1` is 0 on the next edge and the state is IDLE.
   - Re-raising `rx_ready` repeats the scenario 1 timing from that point.
4. Assert `main_reset` mid-WAIT2.
   - All outputs are 0 immediately.
   - After release with `go` = 1, the first command is on channel 1.
5. Force `issued_1` to 16'hFFFE and run three rounds.
   - `issued_1` stays at 16'hFFFF.
   - In a build without `SEND_SCHED_STATS_EN`, all counters read 0 throughout.
6. Over 1000 random cycles of `busy_*` and `go` toggling, assert `cmd_send_1 & cmd_send_2` is never 1.
